int2float_seq: RTL and testbench
================================

INT2FLOAT_SEQ -- requirements
Module: int2float_seq

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1, operand offered.
REQ-004 SHALL have port in_ready, output, 1, block can accept an operand.
REQ-005 SHALL have port int_in, input, 32, integer operand.
REQ-006 SHALL have port is_signed, input, 1: 1 means FCVT.S.W (two's complement), 0 means FCVT.S.WU.
REQ-007 SHALL have port rm, input, 3, static rounding mode, already resolved upstream.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port result, output, 32, IEEE-754 binary32.
REQ-011 SHALL have port fflag_nx, output, 1, inexact flag qualified by out_valid.

Function
REQ-012 SHALL implement FSM states IDLE, NORM, ROUND, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; an operand is accepted when in_valid and in_ready are both 1 on a clock edge.
REQ-014 SHALL on acceptance register int_in, is_signed and rm, then move IDLE->NORM.
REQ-015 SHALL in NORM register sign (int_in[31] & is_signed), 32-bit magnitude (abs value; 0x80000000 signed gives magnitude 0x80000000), leading-zero count lz, and norm = mag << lz, then move to ROUND.
REQ-016 SHALL in ROUND form exp = 158 - lz, mant = norm[30:8], G = norm[7], S = |norm[6:0], inexact = G|S, then move to DONE.
REQ-017 SHALL apply increments as: RNE (000) when G&(S|mant[0]); RTZ (001) never; RDN (010) when inexact&sign; RUP (011) when inexact&!sign; RMM (100) when G; rm 101/110/111 treated as RTZ.
REQ-018 SHALL handle mantissa carry-out by setting mant=0 and exp+1; no overflow is possible.
REQ-019 SHALL map a zero magnitude to result 0x00000000 with nx=0, for any rm and is_signed.
REQ-020 SHALL in DONE hold out_valid=1 with result and fflag_nx stable until out_ready=1, then move DONE->IDLE.
REQ-021 SHALL have latency exactly 3 cycles from the accept edge to out_valid=1, and SHALL accept a new operand no earlier than the cycle after the DONE handshake.
REQ-022 SHALL ignore in_valid in every state other than IDLE.

Reset
REQ-023 SHALL on reset=1 at a clock edge enter IDLE from any state, discarding any in-flight operation.
REQ-024 SHALL reset outputs to in_ready=1, out_valid=0, result=0x00000000, fflag_nx=0.

Configuration
REQ-025 SHALL, with INT2FLOAT_NX_FLAG_EN defined, drive fflag_nx from inexact as registered in ROUND.
REQ-026 SHALL, without INT2FLOAT_NX_FLAG_EN, tie fflag_nx to 0 and omit the inexact register; result is unaffected.

Structure
REQ-027 SHALL place the rounding-mode enum (RNE, RTZ, RDN, RUP, RMM), the FP32_BIAS=127 constant and the FSM state enum in shared package fcvt_pkg.
REQ-028 SHALL implement the leading-zero count in sub-module lzc32 (32-bit in, 5-bit count, purely combinational).

Verification
REQ-029 SHALL cover: unsigned int_in=0x00000001, RNE -> 0x3F800000, nx=0, out_valid exactly 3 cycles after accept.
REQ-030 SHALL cover: unsigned 0xFFFFFFFF, RNE -> 0x4F800000, nx=1 (carry-out path); same operand with RTZ -> 0x4F7FFFFF.
REQ-031 SHALL cover: signed 0x80000000 -> 0xCF000000, nx=0; signed 0xFFFFFFFF with RDN -> 0xBF800000.
REQ-032 SHALL cover: unsigned 0x01000001 -> RNE 0x4B800000, RUP 0x4B800001, RDN 0x4B800000, all nx=1; 0x00000000 -> 0x00000000, nx=0.
REQ-033 SHALL cover: out_ready held 0 for 5 cycles leaves result stable and in_ready=0, with in_valid pulses ignored; reset asserted in ROUND gives out_valid=0 and in_ready=1 next cycle.

Source files
------------

// File: rtl/fcvt_pkg.sv
// fcvt_pkg: rounding modes, FP32 bias and int2float FSM states shared by the converter.
package fcvt_pkg;
    typedef enum logic [2:0] {RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100} rm_e;
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_e;
    localparam int FP32_BIAS = 127;
endpackage

// File: rtl/lzc32.sv
// lzc32: combinational leading-zero count of a 32-bit word (zero input reports 31).
module lzc32 (
    input  logic [31:0] a,
    output logic [4:0]  cnt
);
    always_comb begin
        cnt = 5'd31;
        for (int i = 0; i < 32; i++)
            if (a[i]) cnt = 5'(31 - i);
    end
endmodule

// File: rtl/int2float_seq.sv
// int2float_seq: multi-cycle FCVT.S.W/FCVT.S.WU integer to binary32 converter with valid/ready handshakes.
// Define INT2FLOAT_NX_FLAG_EN to drive fflag_nx from the registered inexact bit; otherwise it is tied low.
module int2float_seq
    import fcvt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] int_in,
    input  logic        is_signed,
    input  logic [2:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        fflag_nx
);
    state_e      state, state_nxt;
    logic [31:0] op_int, mag, norm_full;
    logic        op_signed, sign_q, zero_q;
    logic [2:0]  op_rm;
    logic [4:0]  lz, lz_q;
    logic [30:0] norm_q;
    logic [22:0] mant;
    logic        g, s, inexact, inc;
    logic [23:0] mant_sum;
    logic [7:0]  exp_r;
    logic [31:0] rnd_result;
    assign mag       = (op_signed && op_int[31]) ? -op_int : op_int;
    assign norm_full = mag << lz;
    lzc32 u_lzc (.a(mag), .cnt(lz));
    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        state_nxt = (state == IDLE)  ? (in_valid ? NORM : IDLE) :
                    (state == NORM)  ? ROUND :
                    (state == ROUND) ? DONE :
                    (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            op_int    <= int_in;
            op_signed <= is_signed;
            op_rm     <= rm;
        end
        if (state == NORM) begin
            sign_q <= op_signed & op_int[31];
            zero_q <= ~norm_full[31];
            norm_q <= norm_full[30:0];
            lz_q   <= lz;
        end
    end
    assign mant    = norm_q[30:8];
    assign g       = norm_q[7];
    assign s       = |norm_q[6:0];
    assign inexact = g | s;
    // Unlisted encodings 101..111 fall through to truncation.
    assign inc = (op_rm == RNE) ? g & (s | mant[0]) :
                 (op_rm == RDN) ? inexact & sign_q :
                 (op_rm == RUP) ? inexact & ~sign_q :
                 (op_rm == RMM) ? g : 1'b0;
    assign mant_sum   = {1'b0, mant} + 24'(inc);
    assign exp_r      = 8'(FP32_BIAS + 31) - {3'b0, lz_q} + {7'b0, mant_sum[23]};
    assign rnd_result = zero_q ? 32'h0 : {sign_q, exp_r, mant_sum[22:0]};
    always_ff @(posedge clk)
        if (reset) result <= 32'h0;
        else if (state == ROUND) result <= rnd_result;
`ifdef INT2FLOAT_NX_FLAG_EN
    logic nx_q;
    always_ff @(posedge clk)
        if (reset) nx_q <= 1'b0;
        else if (state == ROUND) nx_q <= inexact & ~zero_q;
    assign fflag_nx = nx_q;
`else
    assign fflag_nx = 1'b0;
`endif
endmodule

// File: tb/tb_int2float_seq.sv
// tb_int2float_seq: directed and randomized checks of int2float_seq against an arithmetic reference model.
module tb_int2float_seq;
    logic        clk = 1'b0, reset, in_valid, in_ready, is_signed, out_valid, out_ready, fflag_nx;
    logic [31:0] int_in, result;
    logic [2:0]  rm;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    int2float_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .int_in(int_in),
        .is_signed(is_signed), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .fflag_nx(fflag_nx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: find the leading one, truncate to 24 significant bits and round on the remainder vs half-ulp.
    function automatic logic [32:0] ref_cvt(input logic [31:0] v, input logic sg, input logic [2:0] r);
        logic   neg, nx, up;
        longint m, q, rem, half;
        int     e, k;
        neg = sg && v[31];
        m = neg ? (64'h1_0000_0000 - longint'(v)) : longint'(v);
        if (m == 0) return 33'h0;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        if (e <= 23) begin
            q = m << (23 - e); rem = 0; half = 1;
        end else begin
            k = e - 23; q = m >> k; rem = m - (q << k); half = longint'(1) << (k - 1);
        end
        nx = rem != 0;
        case (r)
            3'd0:    up = (rem > half) || (rem == half && q[0]);
            3'd2:    up = nx && neg;
            3'd3:    up = nx && !neg;
            3'd4:    up = rem >= half;
            default: up = 1'b0;
        endcase
        q = q + longint'(up);
        if (q == (longint'(1) << 24)) begin q = q >> 1; e++; end
        return {nx, neg, 8'(e + 127), q[22:0]};
    endfunction

    function automatic logic nx_exp(input logic nx);
`ifdef INT2FLOAT_NX_FLAG_EN
        return nx;
`else
        return 1'b0 & nx;
`endif
    endfunction

    task automatic run_op(input string tag, input logic [31:0] v, input logic sg, input logic [2:0] r,
                          input logic [31:0] er, input logic enx);
        @(negedge clk);
        in_valid = 1'b1; int_in = v; is_signed = sg; rm = r;
        @(posedge clk); #1;
        in_valid = 1'b0; int_in = $urandom; is_signed = ~sg; rm = 3'($urandom);
        chk({tag, "/ov_c1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "/ov_c2"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "/ov_c3"}, 32'(out_valid), 32'd1);
        chk({tag, "/result"}, result, er);
        chk({tag, "/nx"}, 32'(fflag_nx), 32'(nx_exp(enx)));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "/idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    typedef struct {logic [31:0] v; logic sg; logic [2:0] r; logic [31:0] res; logic nx;} vec_t;
    vec_t dir[$] = '{
        '{32'h00000001, 1'b0, 3'd0, 32'h3F800000, 1'b0},
        '{32'hFFFFFFFF, 1'b0, 3'd0, 32'h4F800000, 1'b1},
        '{32'hFFFFFFFF, 1'b0, 3'd1, 32'h4F7FFFFF, 1'b1},
        '{32'h80000000, 1'b1, 3'd0, 32'hCF000000, 1'b0},
        '{32'hFFFFFFFF, 1'b1, 3'd2, 32'hBF800000, 1'b0},
        '{32'h01000001, 1'b0, 3'd0, 32'h4B800000, 1'b1},
        '{32'h01000001, 1'b0, 3'd3, 32'h4B800001, 1'b1},
        '{32'h01000001, 1'b0, 3'd2, 32'h4B800000, 1'b1},
        '{32'h00000000, 1'b0, 3'd3, 32'h00000000, 1'b0},
        '{32'h00000000, 1'b1, 3'd4, 32'h00000000, 1'b0}
    };

    initial begin
        logic [32:0] m;
        logic [31:0] v;
        logic [2:0]  r;
        logic        sg;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; int_in = '0; is_signed = 1'b0; rm = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/in_ready", 32'(in_ready), 32'd1);
        chk("reset/out_valid", 32'(out_valid), 32'd0);
        chk("reset/result", result, 32'h0);
        chk("reset/nx", 32'(fflag_nx), 32'd0);
        reset = 1'b0;

        foreach (dir[i])
            run_op($sformatf("dir%0d", i), dir[i].v, dir[i].sg, dir[i].r, dir[i].res, dir[i].nx);

        // Consumer stall with stray in_valid pulses.
        @(negedge clk);
        in_valid = 1'b1; int_in = 32'h3; is_signed = 1'b0; rm = 3'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; int_in = $urandom;
            @(posedge clk); #1;
            chk($sformatf("stall%0d/result", c), result, 32'h40400000);
            chk($sformatf("stall%0d/hs", c), {30'd0, in_ready, out_valid}, 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall/release", {30'd0, in_ready, out_valid}, 32'd2);
        @(posedge clk); #1;
        chk("stall/no_ghost", 32'(out_valid), 32'd0);
        run_op("post_stall", 32'hFFFFFFFF, 1'b0, 3'd1, 32'h4F7FFFFF, 1'b1);

        // Reset while the operation sits in ROUND.
        @(negedge clk);
        in_valid = 1'b1; int_in = 32'h7; is_signed = 1'b0; rm = 3'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_round/hs", {30'd0, in_ready, out_valid}, 32'd2);
        chk("rst_round/result", result, 32'h0);
        @(posedge clk); #1;
        chk("rst_round/stay_idle", 32'(out_valid), 32'd0);

        for (int n = 0; n < 40; n++) begin
            v  = $urandom >> $urandom_range(0, 31);
            sg = 1'($urandom);
            r  = 3'($urandom);
            if (n % 5 == 0) v = v | 32'h80000000;
            m = ref_cvt(v, sg, r);
            run_op($sformatf("rnd%0d_%h_s%0d_rm%0d", n, v, sg, r), v, sg, r, m[31:0], m[32]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
